// File: rtl/vga_timing_gen.sv
// VGA horizontal/vertical timing generator with registered, skew-free outputs.
// Optional macro VGA_PIXEL_DIV2_EN advances the raster on every second pixel_clk edge.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       pixel_clk,
  input  logic       resetSwitch,
  output logic [9:0] col,
  output logic [8:0] row,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start
);

  // Boundaries held at 12 bits so no sum of parameters can wrap.
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0]  hcount_reg, hcount_next;
  logic [9:0]  vcount_reg, vcount_next;
  logic [11:0] hcount_ext, vcount_ext;
  logic        tick;

  logic [9:0] col_reg, col_next;
  logic [8:0] row_reg, row_next;
  logic       hsync_reg, hsync_next;
  logic       vsync_reg, vsync_next;
  logic       video_on_reg, video_on_next;
  logic       line_start_reg, line_start_next;
  logic       frame_start_reg, frame_start_next;

`ifdef VGA_PIXEL_DIV2_EN
  // Toggle starts at 0 so the first edge after reset is a tick.
  logic toggle_reg;
  always_ff @(posedge pixel_clk or negedge resetSwitch) begin
    if (!resetSwitch) toggle_reg <= 1'b0;
    else              toggle_reg <= ~toggle_reg;
  end
  assign tick = ~toggle_reg;
`else
  assign tick = 1'b1;
`endif

  assign hcount_ext = {2'b00, hcount_reg};
  assign vcount_ext = {2'b00, vcount_reg};

  always_comb begin
    hcount_next = hcount_reg + 10'd1;
    vcount_next = vcount_reg;
    if (hcount_ext == H_LAST) begin
      hcount_next = '0;
      vcount_next = (vcount_ext == V_LAST) ? '0 : vcount_reg + 10'd1;
    end
  end

  // Output stage decodes the current counter state; one clock of latency.
  always_comb begin
    video_on_next    = (hcount_ext < H_ACT_END) && (vcount_ext < V_ACT_END);
    col_next         = video_on_next ? hcount_reg : '0;
    row_next         = video_on_next ? vcount_reg[8:0] : '0;
    hsync_next       = !((hcount_ext >= H_SYNC_BEG) && (hcount_ext < H_SYNC_END));
    vsync_next       = !((vcount_ext >= V_SYNC_BEG) && (vcount_ext < V_SYNC_END));
    line_start_next  = (hcount_reg == '0);
    frame_start_next = (hcount_reg == '0) && (vcount_reg == '0);
  end

  always_ff @(posedge pixel_clk or negedge resetSwitch) begin
    if (!resetSwitch) begin
      hcount_reg      <= '0;
      vcount_reg      <= '0;
      col_reg         <= '0;
      row_reg         <= '0;
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      video_on_reg    <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else if (tick) begin
      hcount_reg      <= hcount_next;
      vcount_reg      <= vcount_next;
      col_reg         <= col_next;
      row_reg         <= row_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      video_on_reg    <= video_on_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign col         = col_reg;
  assign row         = row_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign video_on    = video_on_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have port pixel_clk, input, 1, the single clock; all state is on its rising edge.
REQ-010 SHALL have port resetSwitch, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port col, output, 10, horizontal pixel coordinate for the renderer.
REQ-012 SHALL have port row, output, 9, vertical pixel coordinate for the renderer.
REQ-013 SHALL have port hsync, output, 1, horizontal sync, active low.
REQ-014 SHALL have port vsync, output, 1, vertical sync, active low.
REQ-015 SHALL have port video_on, output, 1, high only inside the visible region.
REQ-016 SHALL have port line_start, output, 1, one-tick pulse at hcount 0.
REQ-017 SHALL have port frame_start, output, 1, one-tick pulse at hcount 0, vcount 0.

Function
REQ-018 SHALL keep a 10-bit hcount from 0 to H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800); on each pixel tick it wraps to 0 after H_TOTAL-1 and otherwise increments by 1.
REQ-019 SHALL keep a 10-bit vcount from 0 to V_TOTAL-1 (V_TOTAL = 525); it advances only on the tick where hcount wraps, and wraps to 0 after V_TOTAL-1.
REQ-020 SHALL assert video_on when hcount < H_ACTIVE and vcount < V_ACTIVE.
REQ-021 SHALL drive col = hcount and row = vcount[8:0] while video_on is high, and 0 on both while video_on is low.
REQ-022 SHALL drive hsync low for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751), and high otherwise.
REQ-023 SHALL drive vsync low for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491), and high otherwise.
REQ-024 SHALL register all outputs in the same flops stage, so every output describes the same (hcount,vcount) position with zero relative skew and exactly one pixel_clk of latency from the counter state.
REQ-025 SHALL hold line_start and frame_start for exactly one pixel tick; frame_start implies line_start.
REQ-026 SHALL compute totals and compares at 11 bits or wider, so no intermediate sum overflows for any legal parameter set.

Reset
REQ-027 SHALL, while resetSwitch is low, asynchronously force hcount=0, vcount=0, col=0, row=0, hsync=1, vsync=1, video_on=0, line_start=0, frame_start=0.
REQ-028 SHALL, on the first tick after resetSwitch is released, present position (0,0) with video_on=1, line_start=1, frame_start=1.
REQ-029 SHALL abandon the current frame immediately when reset asserts mid-line or mid-frame; the next frame restarts at (0,0), and no partial sync pulse remains active.

Configuration
REQ-030 SHALL, with macro VGA_PIXEL_DIV2_EN defined, generate an internal toggle clock-enable so counters and outputs advance only on every second pixel_clk edge (50 MHz in, 25 MHz pixel rate); each output value then holds for 2 cycles and pulses last 2 cycles.
REQ-031 SHALL, without VGA_PIXEL_DIV2_EN, advance counters and outputs on every pixel_clk edge; the toggle flop SHALL NOT exist.
REQ-032 SHALL clear the divider toggle on reset, so the first post-reset edge is a tick.

Verification
REQ-033 SHALL cover reset release: after reset -> (col,row)=(0,0), video_on=1, frame_start=1 on the first tick; frame_start recurs exactly 800*525=420000 ticks later.
REQ-034 SHALL cover line boundary: hcount 639->640 -> video_on falls and col=0; hcount 656 -> hsync=0; hcount 752 -> hsync=1; hcount 799->0 -> line_start=1 and vcount increments.
REQ-035 SHALL cover frame boundary: vcount 479 line -> last visible row=479; vcount 490 -> vsync=0 for exactly 1600 ticks; (799,524)->(0,0) -> frame_start=1.
REQ-036 SHALL cover mid-frame reset: assert resetSwitch at (300,200) for 3 cycles -> all outputs take reset values asynchronously; after release the frame restarts at (0,0).
REQ-037 SHALL cover VGA_PIXEL_DIV2_EN defined: 1600 pixel_clk cycles per line, each col value held 2 cycles; without the macro: 800 cycles per line.
REQ-038 SHALL cover non-default parameters (H_ACTIVE=320, V_ACTIVE=240, porches scaled) -> H_TOTAL and V_TOTAL and the sync windows follow REQ-018 to REQ-023 with no counter overflow.
